// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART transmit and receive controllers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int MAX_DATA_BITS = 9;

    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART frame sequencer: start bit, LSB-first data, optional parity, 1-2 stop bits,
// each bit lasting OVERSAMPLE baud ticks from the shared divider.
//
// state  | meaning
// IDLE   | line high, tx_ready high, waiting for tx_valid
// START  | driving the start bit (low)
// DATA   | shifting out data bits, LSB first
// PARITY | driving the parity bit (only when PARITY_EN)
// STOP   | driving STOP_BITS stop bits (high), then back to IDLE
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_ctrl: DATA_BITS must be in 5..9");
    end
    if (OVERSAMPLE < 2) begin : g_bad_oversample
        $error("uart_tx_ctrl: OVERSAMPLE must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
    end

    tx_state_t              r_state;
    logic [TICK_W-1:0]      r_tick_cnt;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic                   r_stop_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parity;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_tx_done;

    logic [MAX_DATA_BITS-1:0] w_data_ext;

    assign w_data_ext = MAX_DATA_BITS'(tx_data);

    // Parity is computed once at accept so the shift register can be consumed freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_valid) begin
                        r_shift    <= tx_data;
                        r_parity   <= parity_bit(w_data_ext, 1'(PARITY_ODD));
                        r_state    <= START;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_tick_cnt <= '0;
                    end
                end
                default: begin
                    if (baud_tick) begin
                        if (r_tick_cnt != TICK_LAST) begin
                            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                        end else begin
                            r_tick_cnt <= '0;
                            case (r_state)
                                START: begin
                                    r_tx      <= r_shift[0];
                                    r_shift   <= r_shift >> 1;
                                    r_bit_cnt <= '0;
                                    r_state   <= DATA;
                                end
                                DATA: begin
                                    if (r_bit_cnt == BIT_LAST) begin
                                        if (PARITY_EN != 0) begin
                                            r_tx    <= r_parity;
                                            r_state <= PARITY;
                                        end else begin
                                            r_tx       <= 1'b1;
                                            r_stop_cnt <= 1'b0;
                                            r_state    <= STOP;
                                        end
                                    end else begin
                                        r_tx      <= r_shift[0];
                                        r_shift   <= r_shift >> 1;
                                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                                    end
                                end
                                PARITY: begin
                                    r_tx       <= 1'b1;
                                    r_stop_cnt <= 1'b0;
                                    r_state    <= STOP;
                                end
                                STOP: begin
                                    if (r_stop_cnt == STOP_LAST) begin
                                        r_state   <= IDLE;
                                        r_busy    <= 1'b0;
                                        r_tx_done <= 1'b1;
                                    end else begin
                                        r_stop_cnt <= r_stop_cnt + 1'b1;
                                    end
                                end
                                default: r_state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign tx_ready = (r_state == IDLE);
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign tx_done  = r_tx_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: four instances cover the default frame, even/odd
// parity and two stop bits; a bench-side bit model supplies every expected value.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [3:0] tx_valid = 4'b0000;
    wire  [3:0] tx_o;
    wire  [3:0] busy_o;
    wire  [3:0] ready_o;
    wire  [3:0] done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_div = 1;
    int tick_phase = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick_phase >= tick_div - 1) begin
            tick_phase = 0;
            baud_tick  = 1'b1;
        end else begin
            tick_phase = tick_phase + 1;
            baud_tick  = 1'b0;
        end
    end

    // 0: default, 1: even parity, 2: odd parity, 3: two stop bits
    uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(4), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_plain (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid[0]),
        .tx_ready(ready_o[0]), .tx(tx_o[0]), .busy(busy_o[0]), .tx_done(done_o[0]));
    uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(4), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_even (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid[1]),
        .tx_ready(ready_o[1]), .tx(tx_o[1]), .busy(busy_o[1]), .tx_done(done_o[1]));
    uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(4), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_odd (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid[2]),
        .tx_ready(ready_o[2]), .tx(tx_o[2]), .busy(busy_o[2]), .tx_done(done_o[2]));
    uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(4), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_stop2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid[3]),
        .tx_ready(ready_o[3]), .tx(tx_o[3]), .busy(busy_o[3]), .tx_done(done_o[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered just before the accept edge (valid already set). Each bit is 4 clk.
    task automatic frame_check(input int sel, input logic [7:0] d, input int n_stop,
                               input bit par_en, input bit par_val,
                               input bit keep_valid, input logic [7:0] next_d, input bit poke);
        logic [11:0] bits;
        int nb;
        int len;
        bits = '0;
        nb = 0;
        bits[nb] = 1'b0; nb = nb + 1;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = d[i]; nb = nb + 1;
        end
        if (par_en) begin
            bits[nb] = par_val; nb = nb + 1;
        end
        for (int i = 0; i < n_stop; i++) begin
            bits[nb] = 1'b1; nb = nb + 1;
        end
        len = nb * 4;

        @(negedge clk);
        if (keep_valid) tx_data = next_d;
        else tx_valid[sel] = 1'b0;
        for (int k = 0; k < len; k++) begin
            chk($sformatf("u%0d_tx_k%0d", sel, k), tx_o[sel], bits[k/4]);
            chk($sformatf("u%0d_busy_k%0d", sel, k), busy_o[sel], 1);
            chk($sformatf("u%0d_ready_k%0d", sel, k), ready_o[sel], 0);
            chk($sformatf("u%0d_done_k%0d", sel, k), done_o[sel], 0);
            if (poke && k == 10) begin
                tx_valid[sel] = 1'b1;
                tx_data = ~d;
            end
            if (poke && k == 11) tx_valid[sel] = 1'b0;
            @(negedge clk);
        end
        chk($sformatf("u%0d_end_tx", sel), tx_o[sel], 1);
        chk($sformatf("u%0d_end_busy", sel), busy_o[sel], 0);
        chk($sformatf("u%0d_end_ready", sel), ready_o[sel], 1);
        chk($sformatf("u%0d_end_done", sel), done_o[sel], 1);
        if (!keep_valid) begin
            @(negedge clk);
            chk($sformatf("u%0d_post_done", sel), done_o[sel], 0);
            chk($sformatf("u%0d_post_busy", sel), busy_o[sel], 0);
        end
    endtask

    initial begin
        int start_len;
        int done_k;
        bit seen_high;
        bit got_done;
        logic [7:0] dec;
        logic stop_s;

        repeat (3) @(negedge clk);
        chk("rst_tx", tx_o, 4'hF);
        chk("rst_ready", ready_o, 4'hF);
        chk("rst_busy", busy_o, 4'h0);
        chk("rst_done", done_o, 4'h0);
        rst = 1'b0;
        @(negedge clk);

        // Plain frame 0xA5
        tx_data = 8'hA5; tx_valid[0] = 1'b1;
        frame_check(0, 8'hA5, 1, 0, 0, 0, 8'h00, 0);

        // Parity of 0x07 has three ones: even -> 1, odd -> 0
        @(negedge clk);
        tx_data = 8'h07; tx_valid[1] = 1'b1;
        frame_check(1, 8'h07, 1, 1, 1'b1, 0, 8'h00, 0);
        @(negedge clk);
        tx_data = 8'h07; tx_valid[2] = 1'b1;
        frame_check(2, 8'h07, 1, 1, 1'b0, 0, 8'h00, 0);

        // Two stop bits, valid held high across two frames
        @(negedge clk);
        tx_data = 8'h55; tx_valid[3] = 1'b1;
        frame_check(3, 8'h55, 2, 0, 0, 1, 8'hAA, 0);
        frame_check(3, 8'hAA, 2, 0, 0, 0, 8'h00, 0);

        // Slow tick: every third cycle, sample at fixed offsets from accept
        tick_div = 3;
        repeat (4) @(negedge clk);
        tx_data = 8'h69; tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        start_len = 0; seen_high = 0; got_done = 0; done_k = 0; dec = 8'h00; stop_s = 1'b0;
        for (int k = 0; k < 200 && !got_done; k++) begin
            if (!seen_high) begin
                if (tx_o[0] == 1'b0) start_len = start_len + 1;
                else seen_high = 1;
            end
            if (k >= 17 && (k - 17) % 12 == 0 && (k - 17) / 12 < 8) dec[(k - 17) / 12] = tx_o[0];
            if (k == 113) stop_s = tx_o[0];
            if (done_o[0]) begin
                got_done = 1;
                done_k = k;
            end else begin
                @(negedge clk);
            end
        end
        chk("tick3_done_seen", got_done, 1);
        chk("tick3_byte", dec, 8'h69);
        chk("tick3_stop", stop_s, 1);
        chk("tick3_start_len_ok", (start_len >= 10 && start_len <= 12), 1);
        chk("tick3_rest_len", done_k - start_len, 108);
        tick_div = 1;
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of 0x00, then a clean 0x3C
        tx_data = 8'h00; tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("rst_mid_pre_tx", tx_o[0], 0);
        chk("rst_mid_pre_busy", busy_o[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_tx", tx_o[0], 1);
        chk("rst_mid_busy", busy_o[0], 0);
        chk("rst_mid_ready", ready_o[0], 1);
        chk("rst_mid_done", done_o[0], 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_idle_tx_%0d", i), tx_o[0], 1);
            chk($sformatf("rst_mid_idle_busy_%0d", i), busy_o[0], 0);
        end
        tx_data = 8'h3C; tx_valid[0] = 1'b1;
        frame_check(0, 8'h3C, 1, 0, 0, 0, 8'h00, 0);

        // valid pulsed and data changed mid-frame must not disturb 0x96
        @(negedge clk);
        tx_data = 8'h96; tx_valid[0] = 1'b1;
        frame_check(0, 8'h96, 1, 0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("poke_idle_busy_%0d", i), busy_o[0], 0);
            chk($sformatf("poke_idle_tx_%0d", i), tx_o[0], 1);
        end

        // rst and tx_valid together: nothing accepted
        rst = 1'b1; tx_valid[0] = 1'b1; tx_data = 8'hF0;
        @(negedge clk);
        rst = 1'b0; tx_valid[0] = 1'b0;
        chk("rst_valid_busy", busy_o[0], 0);
        chk("rst_valid_tx", tx_o[0], 1);
        chk("rst_valid_ready", ready_o[0], 1);
        @(negedge clk);
        chk("rst_valid_busy_after", busy_o[0], 0);
        chk("rst_valid_tx_after", tx_o[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
